// File: rtl/counter_pkg.sv
// Shared encodings and helpers for the up/down counter family.
package counter_pkg;

    // Count direction as carried on the 'up' input.
    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Boundary behaviour as carried on the 'sat' input.
    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    // Bits needed to hold 0..value-1, never less than one so a DIV of 1
    // still gets a (constant) register.
    function automatic int clog2_min1(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Enable prescaler: emits a one-cycle tick once every DIV enabled cycles.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int             PW     = clog2_min1(DIV);
    localparam logic [PW-1:0]  P_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0]  P_ONE  = PW'(1);

    logic [PW-1:0] r_phase;

    // Phase counter: cleared by reset or load, advances only while enabled.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_phase <= '0;
        end else if (en) begin
            if (r_phase == P_LAST) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + P_ONE;
            end
        end
    end

    // With DIV = 1 the phase is stuck at 0 == P_LAST, so tick reduces to en.
    assign tick = en && (r_phase == P_LAST);

endmodule

// File: rtl/updown_counter.sv
// Parametrised up/down counter with wrap/saturate, load, prescaled enable,
// registered terminal-count pulse and combinational zero flag.
module updown_counter
    import counter_pkg::*;
#(
    parameter int N      = 4,
    parameter int MAXVAL = 2**N - 1,
    parameter int DIV    = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] initValue,
    input  logic         load,
    input  logic [N-1:0] loadValue,
    input  logic         en,
    input  logic         up,
    input  logic         sat,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         zero
);

    localparam logic [N-1:0] MAX_V = N'(MAXVAL);
    localparam logic [N-1:0] ONE_V = N'(1);

    logic [N-1:0] r_count;
    logic         r_tc;

    logic         w_step;
    dir_e         w_dir;
    mode_e        w_mode;
    logic         w_at_bound;
    logic [N-1:0] w_next_count;
    logic         w_next_tc;

    function automatic logic [N-1:0] clamp(input logic [N-1:0] x);
        return (x > MAX_V) ? MAX_V : x;
    endfunction

    // A load restarts the prescale period just like reset does.
    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (load),
        .en   (en),
        .tick (w_step)
    );

    assign w_dir  = dir_e'(up);
    assign w_mode = mode_e'(sat);

    // Next count and tc: load beats step; boundary is checked before +/-1
    // so the arithmetic never leaves N bits.
    always_comb begin
        w_next_count = r_count;
        w_next_tc    = 1'b0;
        w_at_bound   = 1'b0;
        if (load) begin
            w_next_count = clamp(loadValue);
        end else if (w_step) begin
            if (w_dir == DIR_UP) begin
                w_at_bound = (r_count == MAX_V);
                if (!w_at_bound) begin
                    w_next_count = r_count + ONE_V;
                end else if (w_mode == MODE_WRAP) begin
                    w_next_count = '0;
                end
            end else begin
                w_at_bound = (r_count == '0);
                if (!w_at_bound) begin
                    w_next_count = r_count - ONE_V;
                end else if (w_mode == MODE_WRAP) begin
                    w_next_count = MAX_V;
                end
            end
            w_next_tc = w_at_bound;
        end
    end

    // Count and tc registers; reset loads the clamped initial value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= clamp(initValue);
            r_tc    <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_tc    <= w_next_tc;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign zero  = (r_count == '0);

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised up/down counter: the next generation of the lab down-counter, extended with programmable width, wrap limit, direction, wrap/saturate mode, synchronous load, enable with a built-in prescaler, and terminal-count and zero flags. It is the general-purpose counter for timers, stopwatches and sequence generators in the lab designs.

## Interface
- N, default 4: counter width in bits; N ≥ 1.
- MAXVAL, default 2**N-1: upper count bound; 1 ≤ MAXVAL ≤ 2**N-1.
- DIV, default 1: prescale ratio; a count step occurs once per DIV enabled cycles; DIV ≥ 1.

Ports:
- clk  in  1: single clock; all state updates on its rising edge.
- rst  in  1: reset, synchronous, active-high; loads initValue.
- initValue  in  N: value loaded on reset.
- load  in  1: synchronous load of loadValue.
- loadValue  in  N: value loaded when load = 1.
- en  in  1: count enable, feeds the prescaler.
- up  in  1: direction; 1 = increment, 0 = decrement.
- sat  in  1: boundary mode; 1 = saturate, 0 = wrap.
- count  out  N: current count, registered.
- tc  out  1: terminal-count pulse, registered.
- zero  out  1: combinational flag, high when count == 0.

## Operation
- Priority per rising edge: rst, then load, then step, then hold.
- rst = 1: count ← clamp(initValue), prescaler ← 0, tc ← 0.
- load = 1: count ← clamp(loadValue), prescaler ← 0, tc ← 0. en is ignored in that cycle.
- clamp(x) = MAXVAL if x > MAXVAL, else x.
- Prescaler: internal counter p of width clog2(DIV) (minimum 1 bit).
  - When en = 1: if p == DIV-1, step = 1 and p ← 0; otherwise p ← p+1.
  - When en = 0: p holds.
  - DIV = 1 means step = en.
- Step, up = 1:
  - count < MAXVAL: count ← count+1.
  - count == MAXVAL: count ← 0 if sat = 0; holds if sat = 1.
- Step, up = 0:
  - count > 0: count ← count-1.
  - count == 0: count ← MAXVAL if sat = 0; holds if sat = 1.
- tc ← 1 when a step occurs with count at the boundary for the current direction (MAXVAL going up, 0 going down), in either mode. Otherwise tc ← 0.
- up and sat are sampled only on step cycles; changing them between steps is legal.
- Arithmetic is N-bit unsigned. No intermediate value exceeds N bits, because the boundary checks come before any +1/-1.

## Timing
- Reset values: count = clamp(initValue), tc = 0, zero = (clamp(initValue) == 0).
- Latency: count updates on the edge that samples step; visible one cycle after en/load/rst are asserted.
- tc is high for exactly one cycle: the cycle after the boundary step, coincident with the wrapped or held value.
- Continuous en with DIV = d: one step every d cycles. The first step comes d edges after en rises from a cleared prescaler.
- rst mid-prescale: prescaler progress is discarded; the next step needs a full DIV enabled cycles.
- Simultaneous rst and load: rst wins. Simultaneous load and step: load wins, and no tc is produced.
- zero follows count combinationally, with no extra latency.

## Structure
- Shared package counter_pkg holds:
  - typedef for the direction encoding: DIR_DOWN = 0, DIR_UP = 1.
  - typedef for the mode encoding: MODE_WRAP = 0, MODE_SAT = 1.
  - function clog2_min1 for the prescaler width.
- One sub-module, tick_prescaler (parameter DIV; ports clk, rst, clr, en, tick), produces the step strobe.
- updown_counter contains the count register, next-value logic, tc register and zero flag.

## Test plan
- N = 2, MAXVAL = 3, DIV = 1; initValue = 3, rst held 1 cycle, then en = 1, up = 0, sat = 0 → count 3, 2, 1, 0, 3. tc is high only in the cycle count = 3 after the wrap.
- N = 4, MAXVAL = 9, up = 1, sat = 0 from count 8 → 9, 0, 1, with tc high alongside the 0. With sat = 1 from 8 → 9, 9, 9, and tc high in each cycle after an attempted step at 9.
- DIV = 3, N = 4, count 0, up = 1, en held high → count reaches 1 after 3 edges and 2 after 6. Dropping en for 2 cycles mid-period delays the next step by exactly 2 cycles.
- load = 1 with loadValue = 12, MAXVAL = 9 → count = 9 next cycle. load together with rst, initValue = 5 → count = 5.
- Counting up at count = 6, assert rst for 1 cycle with initValue = 0 → count = 0, zero = 1, tc = 0. The prescaler restarts with a full DIV delay.
- Toggle up on consecutive steps from count = 4 (up, down, up) → 5, 4, 5, with no tc.
